fun_sweeper: RTL and testbench

FUN_SWEEPER -- requirements
Module: fun_sweeper

---
 rtl/fun_pkg.sv | 6 +
 rtl/fun_sweeper.sv | 97 +++++++++
 tb/tb_fun_sweeper.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/fun_pkg.sv
// fun_pkg: shared golden table, vector width and FSM state encoding for fun_sweeper.
package fun_pkg;
    localparam int VEC_W = 3;
    localparam logic [7:0] FUN_GOLDEN = 8'h39;
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, FIN} state_t;
endpackage

// File: rtl/fun_sweeper.sv
// fun_sweeper: sweeps all 8 input vectors of a 3-input function and checks y_in against FUN_GOLDEN.
// Optional FUN_SWEEPER_FIRST_FAIL_EN adds first_fail/fail_valid outputs.
module fun_sweeper
    import fun_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       y_in,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic [7:0] minterms,
    output logic [3:0] err_count,
    output logic       pass
`ifdef FUN_SWEEPER_FIRST_FAIL_EN
    ,
    output logic [2:0] first_fail,
    output logic       fail_valid
`endif
);
    localparam logic [3:0] LAST = 4'(SETTLE == 0 ? 0 : SETTLE - 1);
    localparam state_t WAIT_ST = SETTLE == 0 ? SAMPLE : DRIVE;

    state_t state, state_nx;
    logic [VEC_W-1:0] idx;
    logic [3:0] cnt;
    logic accept, smp, miss;

    assign accept = state == IDLE && start;
    assign smp = state == SAMPLE;
    assign miss = y_in != FUN_GOLDEN[idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? WAIT_ST : IDLE;
            DRIVE:   state_nx = cnt == LAST ? SAMPLE : DRIVE;
            SAMPLE:  state_nx = idx == 3'd7 ? FIN : WAIT_ST;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = state == DRIVE || state == SAMPLE;
        done = state == FIN;
        {a, b, c} = busy ? idx : 3'b000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
            cnt <= '0;
            minterms <= '0;
            err_count <= '0;
            pass <= 1'b0;
        end else begin
            cnt <= state == DRIVE ? cnt + 4'd1 : 4'd0;
            if (accept) begin
                idx <= '0;
                minterms <= '0;
                err_count <= '0;
                pass <= 1'b0;
            end else if (smp) begin
                idx <= idx + 3'd1;
                minterms[idx] <= y_in;
                err_count <= err_count + {3'b000, miss};
                // verdict is settled on the last sample so it is valid while done is high
                if (idx == 3'd7) pass <= err_count == 4'd0 && !miss;
            end
        end
    end

`ifdef FUN_SWEEPER_FIRST_FAIL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_fail <= '0;
            fail_valid <= 1'b0;
        end else if (accept) begin
            first_fail <= '0;
            fail_valid <= 1'b0;
        end else if (smp && miss && !fail_valid) begin
            first_fail <= idx;
            fail_valid <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_fun_sweeper.sv
// tb_fun_sweeper: directed scoreboard bench for fun_sweeper (SETTLE=1 and SETTLE=0 instances).
module tb_fun_sweeper;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, start0 = 1'b0;
    logic y_in, y0;
    logic a, b, c, busy, done, pass;
    logic a0, b0, c0, busy0, done0, pass0;
    logic [7:0] minterms, minterms0;
    logic [3:0] err_count, err_count0;
`ifdef FUN_SWEEPER_FIRST_FAIL_EN
    logic [2:0] first_fail, first_fail0;
    logic fail_valid, fail_valid0;
`endif
    logic [7:0] gold = 8'h39;
    int y_mode = 0;
    int cyc = 0;
    int checks = 0, failures = 0;

    typedef struct {
        logic [7:0] mt;
        logic [3:0] err;
        logic pass;
        logic [2:0] ff;
        logic fv;
        int due;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign y_in = y_mode == 0 ? gold[{a, b, c}] : y_mode == 1 ? 1'b1 : ~gold[{a, b, c}];
    assign y0 = gold[{a0, b0, c0}];

    fun_sweeper #(.SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .y_in(y_in),
        .a(a), .b(b), .c(c), .busy(busy), .done(done),
        .minterms(minterms), .err_count(err_count), .pass(pass)
`ifdef FUN_SWEEPER_FIRST_FAIL_EN
        , .first_fail(first_fail), .fail_valid(fail_valid)
`endif
    );

    fun_sweeper #(.SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .y_in(y0),
        .a(a0), .b(b0), .c(c0), .busy(busy0), .done(done0),
        .minterms(minterms0), .err_count(err_count0), .pass(pass0)
`ifdef FUN_SWEEPER_FIRST_FAIL_EN
        , .first_fail(first_fail0), .fail_valid(fail_valid0)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int mode, input int due);
        exp_t e;
        logic [7:0] diff;
        e.mt = mode == 0 ? 8'h39 : mode == 1 ? 8'hFF : 8'hC6;
        diff = e.mt ^ 8'h39;
        e.err = '0;
        e.ff = '0;
        e.fv = 1'b0;
        for (int i = 0; i < 8; i++) begin
            e.err += {3'b000, diff[i]};
            if (diff[i] && !e.fv) begin
                e.ff = 3'(i);
                e.fv = 1'b1;
            end
        end
        e.pass = e.err == 0;
        e.due = due;
        return e;
    endfunction

    task automatic launch(input int mode);
        @(negedge clk);
        y_mode = mode;
        start = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back(model(mode, cyc + 16));
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_accept", {31'b0, busy}, 1);
    endtask

    task automatic wait_abc(input logic [2:0] v);
        for (int i = 0; i < 40; i++) begin
            if ({a, b, c} == v && busy) break;
            @(negedge clk);
        end
        chk("reach_vector", {29'b0, a, b, c}, {29'b0, v});
    endtask

    task automatic finish_sweep(input string tag);
        int at;
        exp_t e;
        at = -1;
        for (int i = 0; i < 60; i++) begin
            if (done) begin
                at = cyc;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_done_seen"}, {31'b0, at != -1}, 1);
        e = sb.pop_front();
        chk({tag, "_done_cycle"}, at, e.due);
        chk({tag, "_minterms"}, {24'b0, minterms}, {24'b0, e.mt});
        chk({tag, "_err_count"}, {28'b0, err_count}, {28'b0, e.err});
        chk({tag, "_pass"}, {31'b0, pass}, {31'b0, e.pass});
        chk({tag, "_fin_busy_abc"}, {28'b0, busy, a, b, c}, 0);
`ifdef FUN_SWEEPER_FIRST_FAIL_EN
        chk({tag, "_first_fail"}, {28'b0, fail_valid, first_fail}, {28'b0, e.fv, e.ff});
`endif
        @(negedge clk);
        chk({tag, "_done_single"}, {31'b0, done}, 0);
        chk({tag, "_idle_hold"}, {19'b0, minterms, err_count, pass}, {19'b0, e.mt, e.err, e.pass});
    endtask

    initial begin
        int d1, dcount;
        #13;
        chk("reset_outputs", {15'b0, a, b, c, busy, done, minterms, err_count, pass}, 0);
        chk("reset_outputs0", {15'b0, a0, b0, c0, busy0, done0, minterms0, err_count0, pass0}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_start", {30'b0, busy, done}, 0);

        launch(0);
        finish_sweep("correct");
        launch(1);
        finish_sweep("tied1");
        launch(2);
        finish_sweep("inverse");

        launch(0);
        wait_abc(3'd3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_sweep("ignored_start");
        repeat (3) @(negedge clk);
        chk("no_queued_start", {31'b0, busy}, 0);

        launch(1);
        wait_abc(3'd4);
        rst_n = 1'b0;
        #1;
        chk("async_reset", {15'b0, a, b, c, busy, done, minterms, err_count, pass}, 0);
        void'(sb.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        repeat (20) begin
            @(negedge clk);
            dcount += done;
        end
        chk("no_done_after_abort", dcount, 0);
        launch(0);
        finish_sweep("after_reset");

        start0 = 1'b1;
        d1 = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done0) begin
                d1 = cyc;
                break;
            end
        end
        chk("s0_first_done", {31'b0, d1 != -1}, 1);
        @(negedge clk);
        chk("s0_idle_gap", {28'b0, busy0, a0, b0, c0}, 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("s0_vector_step", {28'b0, busy0, a0, b0, c0}, {28'b0, 1'b1, 3'(k)});
        end
        @(negedge clk);
        chk("s0_done_period", {31'b0, done0}, 1);
        chk("s0_period_cycles", cyc - d1, 10);
        chk("s0_minterms", {20'b0, minterms0, err_count0}, {20'b0, 8'h39, 4'd0});
        repeat (10) @(negedge clk);
        chk("s0_next_done", {31'b0, done0}, 1);
        start0 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
